// File: rtl/multicycle_core.sv
// Multicycle MIPS-style core: FETCH/DECODE/EXEC/MEM/WB/HALT over internal regfile and data memory.
// Latency from instr_valid to next fetch: ALU 3, LW 4, SW 3, branch/jump/DISP 2; stalls in FETCH until instr_valid.
module multicycle_core #(
  parameter int DATA_W  = 8,
  parameter int PC_W    = 8,
  parameter int DMEM_AW = 6,
  parameter int MAX_PC  = 11
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         instr,
  input  logic                instr_valid,
  output logic                instr_req,
  output logic [PC_W-1:0]     pc,
  output logic                done,
  output logic                display_valid,
  output logic [2*DATA_W-1:0] display_value
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HALT  = 6'h3E;
  localparam logic [5:0] OP_DISP  = 6'h3F;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam int          DMEM_D   = 2**DMEM_AW;
  localparam logic [PC_W-1:0] MAX_PC_L = PC_W'(MAX_PC);

  state_t                 state_q, state_d;
  logic [PC_W-1:0]        pc_q, pc_d;
  logic [31:0]            ir_q, ir_d;
  logic [DATA_W-1:0]      a_q, a_d;
  logic [DATA_W-1:0]      b_q, b_d;
  logic [DATA_W-1:0]      alu_q, alu_d;
  logic [DMEM_AW-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]      mdr_q, mdr_d;
  logic [2*DATA_W-1:0]    disp_q, disp_d;
  logic                   done_q, done_d;
  logic                   run_q, run_d;
  logic [DATA_W-1:0]      rf_q [32];
  logic [DATA_W-1:0]      rf_d [32];
  logic [DATA_W-1:0]      mem_q [DMEM_D];
  logic [DATA_W-1:0]      mem_d [DMEM_D];

  logic [5:0]             op, funct;
  logic [4:0]             rs, rt, rd, shamt;
  logic signed [15:0]     imm_s;
  logic [DATA_W-1:0]      imm_data, rs_val;
  logic [PC_W-1:0]        imm_pc, pc_plus1;
  logic [DMEM_AW-1:0]     imm_addr;
  logic [4:0]             wb_dest;
  logic [DATA_W-1:0]      wb_data;

  assign op       = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign shamt    = ir_q[10:6];
  assign funct    = ir_q[5:0];
  assign imm_s    = ir_q[15:0];
  // Sized casts of a signed value sign-extend or truncate as needed.
  assign imm_data = DATA_W'(imm_s);
  assign imm_pc   = PC_W'(imm_s);
  assign imm_addr = DMEM_AW'(imm_s);
  assign pc_plus1 = pc_q + PC_W'(1);
  assign rs_val   = rf_q[rs];
  assign wb_dest  = (op == OP_RTYPE) ? rd : rt;
  assign wb_data  = (op == OP_LW) ? mdr_q : alu_q;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ir_d          = ir_q;
    a_d           = a_q;
    b_d           = b_q;
    alu_d         = alu_q;
    addr_d        = addr_q;
    mdr_d         = mdr_q;
    disp_d        = disp_q;
    run_d         = 1'b1;
    done_d        = done_q | (state_q == S_HALT);
    rf_d          = rf_q;
    mem_d         = mem_q;
    instr_req     = 1'b0;
    display_valid = 1'b0;

    case (state_q)
      S_FETCH: begin
        // run_q holds off the request for the first cycle after reset release.
        instr_req = run_q;
        if (run_q) begin
          if (pc_q > MAX_PC_L) begin
            state_d = S_HALT;
          end else if (instr_valid) begin
            ir_d    = instr;
            state_d = S_DECODE;
          end
        end
      end
      S_DECODE: begin
        a_d     = rs_val;
        b_d     = rf_q[rt];
        if (op == OP_DISP) disp_d = {{DATA_W{rs_val[DATA_W-1]}}, rs_val};
        state_d = S_EXEC;
      end
      S_EXEC: begin
        pc_d    = pc_plus1;
        state_d = S_FETCH;
        case (op)
          OP_RTYPE: begin
            state_d = S_WB;
            pc_d    = pc_q;
            case (funct)
              FN_ADD:  alu_d = a_q + b_q;
              FN_SUB:  alu_d = a_q - b_q;
              FN_AND:  alu_d = a_q & b_q;
              FN_OR:   alu_d = a_q | b_q;
              FN_SLT:  alu_d = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
              FN_SLL:  alu_d = b_q << shamt;
              FN_SRL:  alu_d = b_q >> shamt;
              default: begin
                state_d = S_FETCH;
                pc_d    = pc_plus1;
              end
            endcase
          end
          OP_ADDI: begin
            alu_d   = a_q + imm_data;
            pc_d    = pc_q;
            state_d = S_WB;
          end
          OP_LW, OP_SW: begin
            addr_d  = DMEM_AW'(a_q) + imm_addr;
            pc_d    = pc_q;
            state_d = S_MEM;
          end
          OP_BEQ:  if (a_q == b_q) pc_d = pc_plus1 + imm_pc;
          OP_BNE:  if (a_q != b_q) pc_d = pc_plus1 + imm_pc;
          OP_J:    pc_d = ir_q[PC_W-1:0];
          OP_DISP: display_valid = 1'b1;
          OP_HALT: begin
            pc_d    = pc_q;
            state_d = S_HALT;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        if (op == OP_SW) begin
          mem_d[addr_q] = b_q;
          pc_d          = pc_plus1;
          state_d       = S_FETCH;
        end else begin
          mdr_d   = mem_q[addr_q];
          state_d = S_WB;
        end
      end
      S_WB: begin
        if (wb_dest != 5'd0) rf_d[wb_dest] = wb_data;
        pc_d    = pc_plus1;
        state_d = S_FETCH;
      end
      S_HALT: ;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      alu_q   <= '0;
      addr_q  <= '0;
      mdr_q   <= '0;
      disp_q  <= '0;
      done_q  <= 1'b0;
      run_q   <= 1'b0;
      rf_q    <= '{default: '0};
      mem_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      alu_q   <= alu_d;
      addr_q  <= addr_d;
      mdr_q   <= mdr_d;
      disp_q  <= disp_d;
      done_q  <= done_d;
      run_q   <= run_d;
      rf_q    <= rf_d;
      mem_q   <= mem_d;
    end
  end

  assign pc            = pc_q;
  assign done          = done_q;
  assign display_value = disp_q;

endmodule
